// File: rtl/filter_spad_ctrl.sv
// Filter weight scratchpad controller: loads a filter into the scratchpad, then
// replays it to the MAC for a configurable number of passes through a 2-deep buffer.
module filter_spad_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len_m1,
  input  logic [7:0]        cfg_reps_m1,
  input  logic              cfg_skip_load,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              spad_wr,
  output logic              spad_rd,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_m1, addr;
  logic [7:0]        reps_m1, pass;
  logic              rd_more;
  logic              addr_end, pass_end;
  logic              vld_p0, last_p0, fin_p0;
  logic [1:0]        occ, ahead;
  logic              pop, push;
  logic [DATA_W-1:0] b0_data, b1_data;
  logic              b0_last, b1_last, b0_fin, b1_fin;

  assign addr_end = (addr == len_m1);
  assign pass_end = (pass == reps_m1);
  assign w_valid  = (occ != 2'd0);
  assign pop      = w_valid && w_ready;
  assign push     = vld_p0;
  // Entries that will occupy the buffer once everything already requested lands.
  assign ahead    = occ + {1'b0, vld_p0} - {1'b0, pop};

  assign spad_addr  = addr;
  assign spad_wdata = spad_wr ? ld_data : '0;
  assign w_data     = w_valid ? b0_data : '0;
  assign w_last     = w_valid && b0_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    spad_wr   = 1'b0;
    spad_rd   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = cfg_skip_load ? STREAM : LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        spad_wr  = ld_valid;
        if (ld_valid && addr_end) state_nxt = STREAM;
      end
      STREAM: begin
        spad_rd = rd_more && (ahead <= 2'd1);
        if (pop && b0_fin) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_m1  <= '0;
      reps_m1 <= '0;
      addr    <= '0;
      pass    <= '0;
      rd_more <= 1'b0;
      vld_p0  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      vld_p0 <= spad_rd;
      if (state == IDLE && start) begin
        len_m1  <= cfg_len_m1;
        reps_m1 <= cfg_reps_m1;
        addr    <= '0;
        pass    <= '0;
        rd_more <= 1'b1;
      end
      if (spad_wr) addr <= addr_end ? '0 : addr + ADDR_ONE;
      if (spad_rd) begin
        if (addr_end) begin
          addr <= '0;
          if (pass_end) rd_more <= 1'b0;
          else          pass    <= pass + 8'd1;
        end else begin
          addr <= addr + ADDR_ONE;
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // p0: read request tags, aligned with spad_rdata returning one cycle later
  always_ff @(posedge clk) begin
    last_p0 <= addr_end;
    fin_p0  <= addr_end && pass_end;
  end

  // p1: two-entry output buffer, b0 is the head presented to the MAC
  always_ff @(posedge clk) begin
    if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
      b0_data <= spad_rdata;
      b0_last <= last_p0;
      b0_fin  <= fin_p0;
    end else if (pop) begin
      b0_data <= b1_data;
      b0_last <= b1_last;
      b0_fin  <= b1_fin;
    end
    if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) begin
      b1_data <= spad_rdata;
      b1_last <= last_p0;
      b1_fin  <= fin_p0;
    end
  end

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Directed bench for filter_spad_ctrl with a behavioural scratchpad and
// hand-derived expected weight sequences.
module tb_filter_spad_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, cfg_skip_load, ld_valid, w_ready;
  logic [5:0] cfg_len_m1;
  logic [7:0] cfg_reps_m1, ld_data, spad_rdata;
  logic       ld_ready, spad_wr, spad_rd, w_valid, w_last, busy, done;
  logic [5:0] spad_addr;
  logic [7:0] spad_wdata, w_data;

  filter_spad_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len_m1(cfg_len_m1),
    .cfg_reps_m1(cfg_reps_m1), .cfg_skip_load(cfg_skip_load),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .spad_wr(spad_wr), .spad_rd(spad_rd), .spad_addr(spad_addr),
    .spad_wdata(spad_wdata), .spad_rdata(spad_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (spad_wr) mem[spad_addr] <= spad_wdata;
    if (spad_rd) spad_rdata <= mem[spad_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  logic [7:0]  ld_vec  [64];
  logic [7:0]  exp_mem [64];
  logic [8:0]  acc_q [$];
  logic [13:0] wr_q  [$];
  logic [5:0]  rd_q  [$];
  int n_done, done_cyc, last_acc, first_vld, n_ldready, stall_err, conflicts, busy_end;

  task automatic run_job(input int len, input int reps, input bit skip,
                         input int mode, input int start_at, input int rst_after);
    int cyc, ld_idx, rst_ph;
    bit fin, stall_prev, prev_last;
    logic [7:0] prev_data;
    acc_q.delete(); wr_q.delete(); rd_q.delete();
    n_done = 0; done_cyc = -1; last_acc = -1; first_vld = -1;
    n_ldready = 0; stall_err = 0; busy_end = -1;
    if (!skip) for (int i = 0; i <= len; i++) exp_mem[i] = ld_vec[i];
    cyc = 0; ld_idx = 0; rst_ph = 0; fin = 0; stall_prev = 0;
    prev_data = '0; prev_last = 0;
    @(posedge clk); #1;
    cfg_len_m1 = 6'(len); cfg_reps_m1 = 8'(reps); cfg_skip_load = skip; start = 1'b1;
    while (!fin) begin
      @(posedge clk); #1;
      start = (cyc == start_at);
      cfg_len_m1 = 6'($urandom); cfg_reps_m1 = 8'($urandom); cfg_skip_load = 1'($urandom);
      w_ready  = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      ld_valid = (mode == 0) ? 1'b1 : (cyc % 3 != 1);
      ld_data  = ld_vec[ld_idx % 64];
      if (rst_ph == 1) begin
        rst = 1'b0; rst_ph = 2;
      end else if (rst_after > 0 && rst_ph == 0 && acc_q.size() == rst_after) begin
        rst = 1'b1; rst_ph = 1; w_ready = 1'b0;
      end
      @(negedge clk);
      if (spad_rd && spad_wr) conflicts++;
      if (spad_wr) wr_q.push_back({spad_addr, spad_wdata});
      if (spad_rd) rd_q.push_back(spad_addr);
      if (ld_ready) n_ldready++;
      if (ld_valid && ld_ready) ld_idx++;
      if (stall_prev && (!w_valid || w_data != prev_data || w_last != prev_last)) stall_err++;
      stall_prev = w_valid && !w_ready;
      prev_data = w_data; prev_last = w_last;
      if (w_valid && first_vld < 0) first_vld = cyc;
      if (w_valid && w_ready) begin acc_q.push_back({w_last, w_data}); last_acc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (rst_ph == 2) begin
        check("rst_busy", busy, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_spad_rd", spad_rd, 0);
        fin = 1;
      end
      if (n_done > 0 && cyc >= done_cyc + 3) begin busy_end = busy; fin = 1; end
      cyc++;
      if (cyc > 400 && !fin) begin check("timeout", cyc, 0); fin = 1; end
    end
    w_ready = 1'b1; ld_valid = 1'b0; start = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int len, input int reps);
    int n, e;
    n = (len + 1) * (reps + 1);
    check($sformatf("%s_count", tag), acc_q.size(), n);
    for (int k = 0; k < n && k < acc_q.size(); k++) begin
      e = k % (len + 1);
      check($sformatf("%s_data%0d", tag, k), acc_q[k][7:0], exp_mem[e]);
      check($sformatf("%s_last%0d", tag, k), acc_q[k][8], (e == len) ? 1 : 0);
    end
  endtask

  task automatic check_done(input string tag);
    check($sformatf("%s_ndone", tag), n_done, 1);
    check($sformatf("%s_done_lat", tag), done_cyc - last_acc, 1);
    check($sformatf("%s_busy_end", tag), busy_end, 0);
  endtask

  task automatic check_writes(input string tag, input int len);
    check($sformatf("%s_nwr", tag), wr_q.size(), len + 1);
    for (int i = 0; i <= len && i < wr_q.size(); i++) begin
      check($sformatf("%s_wraddr%0d", tag, i), wr_q[i][13:8], i);
      check($sformatf("%s_wrdata%0d", tag, i), wr_q[i][7:0], ld_vec[i]);
    end
  endtask

  initial begin
    int errs;
    rst = 1'b1; start = 1'b0; cfg_len_m1 = '0; cfg_reps_m1 = '0; cfg_skip_load = 1'b0;
    ld_valid = 1'b0; ld_data = '0; w_ready = 1'b1; conflicts = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);        check("reset_done", done, 0);
    check("reset_ld_ready", ld_ready, 0); check("reset_w_valid", w_valid, 0);
    check("reset_w_last", w_last, 0);    check("reset_spad_rd", spad_rd, 0);
    check("reset_spad_wr", spad_wr, 0);  check("reset_spad_addr", spad_addr, 0);
    check("reset_spad_wdata", spad_wdata, 0); check("reset_w_data", w_data, 0);
    @(posedge clk); #1; rst = 1'b0;

    ld_vec[0] = 8'h11; ld_vec[1] = 8'h22; ld_vec[2] = 8'h33; ld_vec[3] = 8'h44;
    run_job(3, 1, 0, 0, -1, 0);
    check_writes("j1", 3); check_stream("j1", 3, 1); check_done("j1");

    run_job(3, 1, 0, 1, -1, 0);
    check_writes("j2", 3); check_stream("j2", 3, 1); check_done("j2");
    check("j2_stall_stable", stall_err, 0);

    run_job(3, 0, 1, 0, -1, 0);
    check("j3_nwr", wr_q.size(), 0); check("j3_ld_ready", n_ldready, 0);
    check("j3_first_vld", first_vld, 2);
    check_stream("j3", 3, 0); check_done("j3");

    run_job(3, 1, 1, 0, 4, 0);
    check_stream("j4", 3, 1); check_done("j4");

    for (int i = 0; i < 64; i++) ld_vec[i] = 8'(i) ^ 8'hA5;
    run_job(63, 0, 0, 0, -1, 0);
    check_writes("j5", 63); check_stream("j5", 63, 0); check_done("j5");
    check("j5_nrd", rd_q.size(), 64);
    errs = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != 6'(i)) errs++;
    check("j5_rdaddr_err", errs, 0);

    run_job(0, 2, 1, 0, -1, 0);
    check_stream("j6", 0, 2); check_done("j6");

    run_job(3, 1, 1, 0, -1, 2);
    check("j7_acc_before_rst", acc_q.size(), 2);
    check("j7_ndone", n_done, 0);

    run_job(3, 0, 1, 0, -1, 0);
    check("j8_first_rdaddr", (rd_q.size() > 0) ? int'(rd_q[0]) : -1, 0);
    check_stream("j8", 3, 0); check_done("j8");

    check("rd_wr_exclusive", conflicts, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
